// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input function bank through rows 0..7,
// captures each row after a settle time and streams it out with a signature.
module truth_table_sweeper #(
    parameter int NUM_FUNCS     = 9,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 n,
    output logic                 g,
    output logic                 s,
    input  logic [NUM_FUNCS-1:0] f_in,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [2:0]           row_index,
    output logic [NUM_FUNCS-1:0] row_results,
    output logic [NUM_FUNCS-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EMIT,
        DONE
    } state_t;

    // Capture happens on the edge that closes the last settle cycle.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] row_cnt;
    logic [3:0] settle_cnt;

    // Sweep sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row_cnt     <= 3'd0;
            settle_cnt  <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            n           <= 1'b0;
            g           <= 1'b0;
            s           <= 1'b0;
            row_valid   <= 1'b0;
            row_index   <= 3'd0;
            row_results <= '0;
            signature   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        row_cnt    <= 3'd0;
                        {n, g, s}  <= 3'b000;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b1;
                        signature  <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        row_results <= f_in;
                        row_index   <= row_cnt;
                        signature   <= signature ^ f_in;
                        row_valid   <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                EMIT: begin
                    if (row_ready) begin
                        row_valid <= 1'b0;
                        if (row_cnt == 3'd7) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row_cnt    <= row_cnt + 3'd1;
                            {n, g, s}  <= row_cnt + 3'd1;
                            settle_cnt <= 4'd0;
                            state      <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
